// File: rtl/serial_deserializer.sv
// Serial-to-parallel receiver: assembles N framed bits into a held word; word visible right after the edge capturing bit N.
// Output waits in a valid/ready holding register; a word completing while the previous one is still unconsumed is dropped and flagged in Overrun.
module serial_deserializer #(
  parameter int N        = 8,
  parameter bit MsbFirst = 1'b1,
  parameter int CW       = 4
) (
  input  logic          ResetN,
  input  logic          Clock,
  input  logic          Start,
  input  logic          SIn,
  input  logic          SValid,
  input  logic          ClearErr,
  input  logic          OutReady,
  output logic [N-1:0]  Output,
  output logic          OutValid,
  output logic          Busy,
  output logic          Overrun,
  output logic [CW-1:0] BitCount
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [CW-1:0] LastCnt = CW'(N - 1);

  state_t          state_q, state_d;
  logic [N-1:0]    shreg_q, shreg_d;
  logic [N-1:0]    out_q, out_d;
  logic            out_vld_q, out_vld_d;
  logic            ovr_q, ovr_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [N-1:0]    base_shreg;
  logic [CW-1:0]   base_cnt;
  logic [N-1:0]    shifted;
  logic            capture;

  // Start discards any partial frame, so the new bit shifts into a clean register.
  assign base_shreg = Start ? '0 : shreg_q;
  assign base_cnt   = Start ? '0 : cnt_q;
  assign capture    = SValid && (Start || (state_q == SHIFT));

  generate
    if (N == 1) begin : g_one
      assign shifted = SIn;
    end else if (MsbFirst) begin : g_msb
      assign shifted = {base_shreg[N-2:0], SIn};
    end else begin : g_lsb
      assign shifted = {SIn, base_shreg[N-1:1]};
    end
  endgenerate

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    cnt_d     = cnt_q;
    out_d     = out_q;
    out_vld_d = out_vld_q;
    ovr_d     = ovr_q;

    if (out_vld_q && OutReady) begin
      out_vld_d = 1'b0;
    end
    if (ClearErr) begin
      ovr_d = 1'b0;
    end

    if (Start) begin
      state_d = SHIFT;
      shreg_d = '0;
      cnt_d   = '0;
    end

    if (capture) begin
      shreg_d = shifted;
      if (base_cnt == LastCnt) begin
        state_d = IDLE;
        cnt_d   = '0;
        // Holding register free (or freed this cycle): load; otherwise drop and flag.
        if (!out_vld_q || OutReady) begin
          out_d     = shifted;
          out_vld_d = 1'b1;
        end else begin
          ovr_d = 1'b1;
        end
      end else begin
        state_d = SHIFT;
        cnt_d   = base_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      cnt_q     <= '0;
      out_q     <= '0;
      out_vld_q <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      cnt_q     <= cnt_d;
      out_q     <= out_d;
      out_vld_q <= out_vld_d;
      ovr_q     <= ovr_d;
    end
  end

  assign Output   = out_q;
  assign OutValid = out_vld_q;
  assign Busy     = (state_q == SHIFT);
  assign Overrun  = ovr_q;
  assign BitCount = cnt_q;

endmodule
